// File: rtl/imem_load_controller.sv
// UART boot loader: parses a framed instruction image, writes it to instruction
// memory, zero-fills the unused tail and releases the CPU once the checksum matches.
module imem_load_controller #(
   parameter logic [7:0] HEADER         = 8'hA5,
   parameter int         DEPTH          = 32,
   parameter int         TIMEOUT_CYCLES = 1000000,
   localparam int        ADDR_W         = $clog2(DEPTH)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   input  logic              start,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_error
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, COUNT, HI, LO, CSUM, FILL, DONE, ERROR} state_t;

   state_t             state, state_nx;
   logic [CNT_W-1:0]   n;
   logic [ADDR_W-1:0]  idx;
   logic [7:0]         csum;
   logic [7:0]         hi;
   logic [GAP_W-1:0]   gap;
   logic               in_frame;
   logic               timeout;
   logic               count_ok;
   logic               last_word;
   logic               fill_needed;

   assign in_frame    = (state == COUNT) || (state == HI) || (state == LO) || (state == CSUM);
   assign timeout     = in_frame && !rx_valid && (int'(gap) == TIMEOUT_CYCLES - 1);
   assign count_ok    = (rx_data != 8'd0) && (int'(rx_data) <= DEPTH);
   assign last_word   = (int'(idx) + 1 == int'(n));
   assign fill_needed = (int'(n) < DEPTH);

   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (start) begin
         state_nx = IDLE;
      end else if (timeout) begin
         state_nx = ERROR;
      end else begin
         case (state)
            IDLE:  if (rx_valid && rx_data == HEADER) state_nx = COUNT;
            COUNT: if (rx_valid) state_nx = count_ok ? HI : ERROR;
            HI:    if (rx_valid) state_nx = LO;
            LO:    if (rx_valid) state_nx = last_word ? CSUM : HI;
            CSUM:  if (rx_valid) state_nx = (rx_data != csum) ? ERROR : (fill_needed ? FILL : DONE);
            // The write on display is the last one once it reaches the top address.
            FILL:  if (mem_addr == ADDR_W'(DEPTH - 1)) state_nx = DONE;
            default: state_nx = state;
         endcase
      end
   end

   always_comb begin
      cpu_hold   = (state != DONE);
      load_done  = (state == DONE);
      load_error = (state == ERROR);
   end

   // Fill writes are issued one cycle early so the last one lands inside FILL.
   always_ff @(posedge CLK) begin
      if (RST) begin
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         n         <= '0;
         idx       <= '0;
         csum      <= '0;
         hi        <= '0;
         gap       <= '0;
      end else begin
         mem_we <= 1'b0;
         if (start) begin
            idx  <= '0;
            csum <= '0;
            gap  <= '0;
         end else begin
            if (rx_valid || !in_frame) gap <= '0;
            else                       gap <= gap + GAP_W'(1);
            case (state)
               COUNT: if (rx_valid && count_ok) begin
                  n    <= rx_data[CNT_W-1:0];
                  idx  <= '0;
                  csum <= '0;
               end
               HI: if (rx_valid) begin
                  hi   <= rx_data;
                  csum <= csum + rx_data;
               end
               LO: if (rx_valid) begin
                  csum      <= csum + rx_data;
                  mem_we    <= 1'b1;
                  mem_addr  <= idx;
                  mem_wdata <= {hi, rx_data};
                  idx       <= idx + ADDR_W'(1);
               end
               CSUM: if (rx_valid && rx_data == csum && fill_needed) begin
                  mem_we    <= 1'b1;
                  mem_addr  <= idx;
                  mem_wdata <= '0;
                  idx       <= idx + ADDR_W'(1);
               end
               FILL: if (mem_addr != ADDR_W'(DEPTH - 1)) begin
                  mem_we    <= 1'b1;
                  mem_addr  <= idx;
                  mem_wdata <= '0;
                  idx       <= idx + ADDR_W'(1);
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_load_controller.sv
// Bench for imem_load_controller: a frame-level model predicts the write stream
// and final status; a compare process checks every write and the status outputs.
module tb_imem_load_controller;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        start = 1'b0;
   logic        mem_we;
   logic [4:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic        cpu_hold, load_done, load_error;

   always #5 CLK = ~CLK;

   imem_load_controller #(.HEADER(8'hA5), .DEPTH(32), .TIMEOUT_CYCLES(16)) dut (
      .CLK(CLK), .RST(RST), .rx_valid(rx_valid), .rx_data(rx_data), .start(start),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error)
   );

   typedef struct packed {logic [4:0] a; logic [15:0] d;} wr_t;

   wr_t        exp_q[$];
   logic [7:0] frame_q[$];
   wr_t        last_wr;
   wr_t        e;
   int         n_cmp = 0;
   int         n_bad = 0;
   int         st;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Every write the DUT makes must be the next one the model predicted.
   always @(negedge CLK) begin
      if (mem_we === 1'b1) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_write: got addr %0h data %h, expected no write", mem_addr, mem_wdata);
         end else begin
            e = exp_q.pop_front();
            if ({mem_addr, mem_wdata} !== e) begin
               n_bad++;
               $display("FAIL write: got addr %0h data %h expected addr %0h data %h",
                        mem_addr, mem_wdata, e.a, e.d);
            end
         end
         last_wr = {mem_addr, mem_wdata};
      end
      if (!RST) begin
         n_cmp++;
         if (cpu_hold !== !load_done || (load_done && load_error) || $isunknown({cpu_hold, load_done, load_error})) begin
            n_bad++;
            $display("FAIL status: got hold %b done %b err %b", cpu_hold, load_done, load_error);
         end
      end
   end

   // Frame-level model: returns 1 done, 2 error, 0 still idle; queues expected writes.
   task automatic model(output int res);
      int i, n, sum;
      logic [7:0] h, l;
      res = 0;
      i = 0;
      while (i < frame_q.size() && frame_q[i] != 8'hA5) i++;
      if (i >= frame_q.size()) return;
      i++;
      res = 2;
      if (i >= frame_q.size()) return;
      n = int'(frame_q[i]);
      i++;
      if (n == 0 || n > 32) return;
      sum = 0;
      for (int k = 0; k < n; k++) begin
         if (i + 1 >= frame_q.size()) return;
         h = frame_q[i];
         l = frame_q[i+1];
         i += 2;
         exp_q.push_back({5'(k), h, l});
         sum = (sum + int'(h) + int'(l)) % 256;
      end
      if (i >= frame_q.size()) return;
      if (int'(frame_q[i]) != sum) return;
      for (int a = n; a < 32; a++) exp_q.push_back({5'(a), 16'h0000});
      res = 1;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      rx_valid = 1'b1;
      rx_data  = b;
      tick(1);
      rx_valid = 1'b0;
      tick(gap);
   endtask

   // Last byte has no trailing gap so the caller sees the cycle right after it.
   task automatic run(output int res);
      model(res);
      for (int i = 0; i < frame_q.size(); i++) send(frame_q[i], (i == frame_q.size() - 1) ? 0 : 1);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] cs;
      tick(3);
      chk("rst_we", mem_we, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_hold", cpu_hold, 1);
      chk("rst_done", load_done, 0);
      chk("rst_err", load_error, 0);
      RST = 1'b0;
      tick(2);

      // single word, then 31 fill cycles
      frame_q = '{8'hA5, 8'h01, 8'h40, 8'hAA, 8'hEA};
      run(st);
      chk("t1_model", st, 1);
      chk("t1_word0", last_wr, {5'd0, 16'h40AA});
      tick(30);
      chk("t1_done_early", load_done, 0);
      tick(1);
      chk("t1_done", load_done, 1);
      chk("t1_hold", cpu_hold, 0);
      chk("t1_err", load_error, 0);
      chk("t1_q", exp_q.size(), 0);
      chk("t1_lastfill", last_wr, {5'd31, 16'h0000});

      // full 32-word image, DONE right after the checksum
      pulse_start();
      chk("t2_restart_done", load_done, 0);
      chk("t2_restart_hold", cpu_hold, 1);
      frame_q = '{8'hA5, 8'h20};
      cs = 8'h00;
      for (int k = 0; k < 32; k++) begin
         frame_q.push_back(8'(k));
         frame_q.push_back(8'(k * 7 + 3));
         cs = cs + 8'(k) + 8'(k * 7 + 3);
      end
      frame_q.push_back(cs);
      run(st);
      chk("t2_done", load_done, 1);
      chk("t2_we", mem_we, 0);
      chk("t2_q", exp_q.size(), 0);
      chk("t2_word31", last_wr, {5'd31, 16'h1FDC});

      // bad checksum
      pulse_start();
      frame_q = '{8'hA5, 8'h01, 8'h40, 8'hAA, 8'hEB};
      run(st);
      chk("t3_model", st, 2);
      chk("t3_err", load_error, 1);
      chk("t3_hold", cpu_hold, 1);
      tick(5);
      chk("t3_q", exp_q.size(), 0);
      chk("t3_word0", last_wr, {5'd0, 16'h40AA});

      // bad counts, then a good frame after start
      pulse_start();
      frame_q = '{8'hA5, 8'h00};
      run(st);
      chk("t4_zero_err", load_error, 1);
      tick(3);
      pulse_start();
      chk("t4_start_err", load_error, 0);
      frame_q = '{8'hA5, 8'h21};
      run(st);
      chk("t4_big_err", load_error, 1);
      pulse_start();
      frame_q = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h46};
      run(st);
      chk("t4_model", st, 1);
      tick(31);
      chk("t4_done", load_done, 1);
      chk("t4_q", exp_q.size(), 0);

      // stray bytes ignored, then inter-byte timeout
      pulse_start();
      frame_q = '{8'h00, 8'hFF, 8'hA5, 8'h02, 8'h40};
      run(st);
      tick(15);
      chk("t5_err_early", load_error, 0);
      tick(1);
      chk("t5_err", load_error, 1);
      chk("t5_hold", cpu_hold, 1);

      // reset in the middle of FILL
      pulse_start();
      frame_q = '{8'hA5, 8'h01, 8'h40, 8'hAA, 8'hEA};
      run(st);
      tick(5);
      RST = 1'b1;
      tick(1);
      RST = 1'b0;
      exp_q.delete();
      chk("t6_we", mem_we, 0);
      chk("t6_addr", mem_addr, 0);
      chk("t6_wdata", mem_wdata, 0);
      chk("t6_hold", cpu_hold, 1);
      tick(40);
      chk("t6_done", load_done, 0);

      // start and a header byte together during HI: byte is dropped
      send(8'hA5, 1);
      send(8'h02, 1);
      rx_valid = 1'b1;
      rx_data  = 8'hA5;
      start    = 1'b1;
      tick(1);
      rx_valid = 1'b0;
      start    = 1'b0;
      chk("t7_err", load_error, 0);
      chk("t7_hold", cpu_hold, 1);
      send(8'h01, 1);
      send(8'h12, 1);
      send(8'h34, 1);
      send(8'h46, 1);
      tick(30);
      chk("t7_idle_done", load_done, 0);
      chk("t7_idle_err", load_error, 0);
      frame_q = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h46};
      run(st);
      tick(31);
      chk("t7_done", load_done, 1);
      chk("t7_q", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
